// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with prescaler, parallel load, clear and carry/overflow.
// Define PARAM_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module param_updown_counter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int unsigned DIV     = 1
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned      PreW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] One     = WIDTH'(1);
    localparam logic [PreW-1:0]  PreLast = PreW'(DIV - 1);
    localparam logic [PreW-1:0]  PreOne  = PreW'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [PreW-1:0]  pre_q, pre_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             at_limit;
    logic [WIDTH-1:0] step_val;

    assign tick     = en && (pre_q == PreLast);
    assign at_limit = up ? (q_q == MaxVal) : (q_q == '0);

    // Explicit MAX_VAL comparison so non-power-of-two moduli wrap correctly.
    always_comb begin
        step_val = q_q;
        if (!at_limit) begin
            step_val = up ? (q_q + One) : (q_q - One);
        end else begin
`ifdef PARAM_COUNTER_SATURATE_EN
            step_val = q_q;
`else
            step_val = up ? '0 : MaxVal;
`endif
        end
    end

    always_comb begin
        q_d     = q_q;
        pre_d   = pre_q;
        carry_d = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            q_d   = '0;
            pre_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            q_d   = (din > MaxVal) ? MaxVal : din;
            pre_d = '0;
        end else if (tick) begin
            pre_d = '0;
            q_d   = step_val;
            if (at_limit) begin
                carry_d = 1'b1;
                ovf_d   = 1'b1;
            end
        end else if (en) begin
            pre_d = pre_q + PreOne;
        end
    end

    always_ff @(posedge clock) begin
        if (!Reset) begin
            q_q     <= '0;
            pre_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            pre_q   <= pre_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q     = q_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter: two configurations share one stimulus stream and are
// checked against an integer reference model of the counting rules.
module tb_param_updown_counter;

    typedef struct packed {
        logic       tk_known;
        logic       tk;
        logic [3:0] q;
        logic       c;
        logic       o;
    } exp_t;

    logic       clock = 1'b0;
    logic       rst_n, en, up, ld, clr;
    logic [3:0] din;
    logic [3:0] qa, qb;
    logic       tka, tkb, ca, cb, oa, ob;

    int checks   = 0;
    int failures = 0;
    bit drv_done = 0;

    exp_t exp_qa[$];
    exp_t exp_qb[$];

    int mq[2];
    int mpre[2];
    bit movf[2];
    bit known[2] = '{0, 0};

    always #5 clock = ~clock;

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .DIV(3)) dut_a (
        .clock(clock), .Reset(rst_n), .en(en), .up(up), .load(ld), .din(din), .clr(clr),
        .q(qa), .tick(tka), .carry(ca), .ovf(oa)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .DIV(1)) dut_b (
        .clock(clock), .Reset(rst_n), .en(en), .up(up), .load(ld), .din(din), .clr(clr),
        .q(qb), .tick(tkb), .carry(cb), .ovf(ob)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: count in plain integers modulo MAX_VAL+1.
    task automatic model_step(input int i, output exp_t e);
        int  maxv = (i == 0) ? 9 : 15;
        int  divv = (i == 0) ? 3 : 1;
        bit  c    = 0;
        e.tk_known = known[i];
        e.tk       = en && (mpre[i] == divv - 1);
        if (!rst_n || clr) begin
            mq[i] = 0; mpre[i] = 0; movf[i] = 0; known[i] = 1;
        end else if (ld) begin
            mq[i]   = (int'(din) > maxv) ? maxv : int'(din);
            mpre[i] = 0;
        end else if (en) begin
            if (mpre[i] < divv - 1) begin
                mpre[i]++;
            end else begin
                int nxt;
                mpre[i] = 0;
                nxt = up ? mq[i] + 1 : mq[i] - 1;
                if (nxt > maxv || nxt < 0) begin
                    c = 1; movf[i] = 1;
`ifdef PARAM_COUNTER_SATURATE_EN
                    nxt = mq[i];
`else
                    nxt = (nxt + maxv + 1) % (maxv + 1);
`endif
                end
                mq[i] = nxt;
            end
        end
        e.q = 4'(mq[i]);
        e.c = c;
        e.o = movf[i];
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit l, input int d,
                         input bit cl);
        exp_t ea, eb;
        @(negedge clock);
        rst_n = r; en = e; up = u; ld = l; din = 4'(d); clr = cl;
        model_step(0, ea);
        model_step(1, eb);
        exp_qa.push_back(ea);
        exp_qb.push_back(eb);
    endtask

    task automatic settle();
        @(posedge clock);
        #1;
    endtask

    // Monitor: tick checked mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t ea, eb;
        forever begin
            @(negedge clock);
            #2;
            if (exp_qa.size() > 0 && exp_qb.size() > 0) begin
                ea = exp_qa.pop_front();
                eb = exp_qb.pop_front();
                if (ea.tk_known) chk("tick_a", 32'(tka), 32'(ea.tk));
                if (eb.tk_known) chk("tick_b", 32'(tkb), 32'(eb.tk));
                @(posedge clock);
                #1;
                chk("q_a", 32'(qa), 32'(ea.q));
                chk("carry_a", 32'(ca), 32'(ea.c));
                chk("ovf_a", 32'(oa), 32'(ea.o));
                chk("q_b", 32'(qb), 32'(eb.q));
                chk("carry_b", 32'(cb), 32'(eb.c));
                chk("ovf_b", 32'(ob), 32'(eb.o));
            end
        end
    end

    initial begin
`ifdef PARAM_COUNTER_SATURATE_EN
        bit sat = 1;
`else
        bit sat = 0;
`endif
        rst_n = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; din = '0; clr = 1'b0;

        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        settle();
        chk("reset_q_b", 32'(qb), 0);
        for (int i = 0; i < 12; i++) drive(1, 1, 1, 0, 0, 0);
        settle();
        chk("presc_q_a", 32'(qa), 4);
        chk("count_q_b", 32'(qb), 12);

        drive(1, 1, 1, 1, 12, 0);
        settle();
        chk("clamp_q_a", 32'(qa), 9);
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0, 0);
        settle();
        chk("upwrap_q_a", 32'(qa), sat ? 9 : 0);
        chk("upwrap_carry_a", 32'(ca), 1);
        chk("upwrap_ovf_a", 32'(oa), 1);
        drive(1, 1, 1, 0, 0, 1);
        settle();
        chk("clr_ovf_a", 32'(oa), 0);

        drive(1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0);
        settle();
        chk("downwrap_q_a", 32'(qa), sat ? 0 : 9);
        chk("downwrap_carry_a", 32'(ca), 1);

        drive(1, 1, 1, 1, 5, 1);
        settle();
        chk("clr_over_load_q_a", 32'(qa), 0);
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 1, 5, 0);
        settle();
        chk("load_over_tick_q_a", 32'(qa), 5);
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        settle();
        chk("pre_restart_q_a", 32'(qa), 5);

        for (int i = 0; i < 3000; i++) begin
            bit r  = ($urandom_range(99) >= 2);
            bit cl = ($urandom_range(99) < 3);
            bit l  = ($urandom_range(99) < 5);
            bit e  = ($urandom_range(99) < 75);
            bit u  = ($urandom_range(99) < 60);
            drive(r, e, u, l, int'($urandom_range(15)), cl);
        end
        drv_done = 1;

        for (int i = 0; i < 20 && exp_qa.size() > 0; i++) @(posedge clock);
        repeat (2) @(posedge clock);
        if (exp_qa.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_qa.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
